// File: rtl/multdiv_ctrl.sv
// Sequencer that hands X-stage MUL/DIV instructions to an iterative multiplier/divider
// and writes the result back. Define MULTDIV_TIMEOUT_EN to enable the WAIT-state watchdog.
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] ins,
  input  logic        valid_x,
  input  logic        flush,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  input  logic [31:0] mdu_result,
  input  logic        mdu_exception,
  input  logic        mdu_ready,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_e;

  localparam logic [4:0] OP_MUL  = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;
  localparam logic [4:0] EXC_RD  = 5'd30;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        op_div_q;
  logic [4:0]  rd_q;
  logic [31:0] mdu_a_q, mdu_b_q, wb_data_q;
  logic        ctrl_mult_q, ctrl_div_q, wb_valid_q;
  logic [4:0]  wb_rd_q;

  logic is_rtype, is_mul, is_div, accept, timeout_hit, wb_fire, wb_exc;
  logic unused_ins;

  assign is_rtype = (ins[31:27] == 5'b00000);
  assign is_mul   = is_rtype & (ins[6:2] == OP_MUL);
  assign is_div   = is_rtype & (ins[6:2] == OP_DIV);
  assign accept   = valid_x & (is_mul | is_div) & (state_q == S_IDLE) & ~flush;
  assign unused_ins = ^{ins[21:7], ins[1:0]};

`ifdef MULTDIV_TIMEOUT_EN
  // The counter holds the number of completed idle WAIT cycles, so the last allowed one sees TIMEOUT-1.
  assign timeout_hit = (state_q == S_WAIT) & ~mdu_ready & (cnt_q == 6'(TIMEOUT - 1));
`else
  logic [5:0] unused_timeout;
  assign unused_timeout = 6'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  // A timeout without ready is reported the same way as an MDU exception.
  assign wb_fire = (state_q == S_WAIT) & ~flush & (mdu_ready | timeout_hit);
  assign wb_exc  = mdu_ready ? mdu_exception : 1'b1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: begin
        state_d = flush ? S_IDLE : S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (flush)        state_d = S_IDLE;
        else if (wb_fire) state_d = S_WB;
        else if (cnt_q != 6'h3f) cnt_d = cnt_q + 6'd1;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_div_q    <= 1'b0;
      rd_q        <= '0;
      mdu_a_q     <= '0;
      mdu_b_q     <= '0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      ctrl_mult_q <= accept & is_mul;
      ctrl_div_q  <= accept & is_div;
      wb_valid_q  <= wb_fire;
      if (accept) begin
        op_div_q <= is_div;
        rd_q     <= ins[26:22];
        mdu_a_q  <= operand_a;
        mdu_b_q  <= operand_b;
      end
      if (wb_fire) begin
        wb_rd_q   <= wb_exc ? EXC_RD : rd_q;
        wb_data_q <= wb_exc ? (op_div_q ? 32'd5 : 32'd4) : mdu_result;
      end
    end
  end

  assign mdu_a     = mdu_a_q;
  assign mdu_b     = mdu_b_q;
  assign ctrl_mult = ctrl_mult_q;
  assign ctrl_div  = ctrl_div_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  // The X instruction is frozen from the accept cycle until the result is on its way to writeback.
  assign stall     = reset_n & (accept | (state_q == S_ISSUE) | (state_q == S_WAIT));

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl; expectations follow MULTDIV_TIMEOUT_EN the same way the RTL does.
module tb_multdiv_ctrl;

  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] ins = '0;
  logic        valid_x = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic [31:0] mdu_a, mdu_b;
  logic        ctrl_mult, ctrl_div;
  logic [31:0] mdu_result = '0;
  logic        mdu_exception = 1'b0;
  logic        mdu_ready = 1'b0;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int bad = 0;

  multdiv_ctrl #(.TIMEOUT(40)) dut (
    .clock(clock), .reset_n(reset_n), .ins(ins), .valid_x(valid_x), .flush(flush),
    .operand_a(operand_a), .operand_b(operand_b), .mdu_a(mdu_a), .mdu_b(mdu_b),
    .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .mdu_result(mdu_result),
    .mdu_exception(mdu_exception), .mdu_ready(mdu_ready), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] top = 5'b00000);
    return {top, rd, 15'h0, op, 2'b11};
  endfunction

  // Cycle 0 presents the instruction; cycles 1..n follow. Outputs sampled mid-cycle.
  task automatic run_op(input logic [31:0] i_ins, input logic [31:0] a, input logic [31:0] b,
                        input int rlo, input int rhi, input logic [31:0] res, input logic exc,
                        input int fc, input int n,
                        output int st_cnt, output int mul_cnt, output int div_cnt,
                        output int wb_cnt, output int wb_cyc, output logic [4:0] rd_seen,
                        output logic [31:0] data_seen, output logic [127:0] st_trace);
    st_cnt = 0; mul_cnt = 0; div_cnt = 0; wb_cnt = 0; wb_cyc = -1;
    rd_seen = '0; data_seen = '0; st_trace = '0;
    for (int c = 0; c <= n; c++) begin
      @(posedge clock); #1;
      valid_x       = (c == 0);
      ins           = i_ins;
      operand_a     = (c == 0) ? a : ~a;
      operand_b     = (c == 0) ? b : ~b;
      mdu_ready     = (c >= rlo) && (c <= rhi);
      mdu_result    = mdu_ready ? res : 32'hDEAD_BEEF;
      mdu_exception = mdu_ready & exc;
      flush         = (c == fc);
      #1;
      st_trace[c] = stall;
      st_cnt  += int'(stall);
      mul_cnt += int'(ctrl_mult);
      div_cnt += int'(ctrl_div);
      if (wb_valid) begin
        wb_cnt++; wb_cyc = c; rd_seen = wb_rd; data_seen = wb_data;
      end
    end
    valid_x = 1'b0; mdu_ready = 1'b0; mdu_exception = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; valid_x = 1'b1; ins = mk(OP_MUL, 5'd3); operand_a = 32'd1; operand_b = 32'd2;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %0d want 0", stall); end
    checks++; if ({ctrl_mult, ctrl_div, wb_valid} !== 3'b000) begin bad++; $display("FAIL reset_pulses: got %b want 000", {ctrl_mult, ctrl_div, wb_valid}); end
    checks++; if (mdu_a !== 32'd0) begin bad++; $display("FAIL reset_mdu_a: got %0h want 0", mdu_a); end
    checks++; if (mdu_b !== 32'd0) begin bad++; $display("FAIL reset_mdu_b: got %0h want 0", mdu_b); end
    checks++; if (wb_rd !== 5'd0) begin bad++; $display("FAIL reset_wb_rd: got %0d want 0", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin bad++; $display("FAIL reset_wb_data: got %0h want 0", wb_data); end
    valid_x = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_mul_basic();
    int st, mc, dc, wc, wy; logic [4:0] rd; logic [31:0] d; logic [127:0] tr;
    run_op(mk(OP_MUL, 5'd3), 32'd6, 32'd7, 18, 18, 32'd42, 1'b0, -1, 25, st, mc, dc, wc, wy, rd, d, tr);
    checks++; if (mc !== 1 || dc !== 0) begin bad++; $display("FAIL mul_pulses: got mult=%0d div=%0d want 1/0", mc, dc); end
    checks++; if (st !== 19) begin bad++; $display("FAIL mul_stall_cycles: got %0d want 19", st); end
    checks++; if (wc !== 1 || wy !== 19) begin bad++; $display("FAIL mul_wb_timing: got count=%0d cycle=%0d want 1/19", wc, wy); end
    checks++; if (rd !== 5'd3 || d !== 32'd42) begin bad++; $display("FAIL mul_wb_value: got rd=%0d data=%0d want 3/42", rd, d); end
    checks++; if (mdu_a !== 32'd6 || mdu_b !== 32'd7) begin bad++; $display("FAIL mul_operands: got %0d/%0d want 6/7", mdu_a, mdu_b); end
    idle(2);
  endtask

  task automatic test_div_exception();
    int st, mc, dc, wc, wy; logic [4:0] rd; logic [31:0] d; logic [127:0] tr;
    run_op(mk(OP_DIV, 5'd5), 32'd10, 32'd0, 5, 5, 32'h1234, 1'b1, -1, 9, st, mc, dc, wc, wy, rd, d, tr);
    checks++; if (mc !== 0 || dc !== 1) begin bad++; $display("FAIL div_pulses: got mult=%0d div=%0d want 0/1", mc, dc); end
    checks++; if (wc !== 1 || wy !== 6) begin bad++; $display("FAIL div_exc_timing: got count=%0d cycle=%0d want 1/6", wc, wy); end
    checks++; if (rd !== 5'd30 || d !== 32'd5) begin bad++; $display("FAIL div_exc_value: got rd=%0d data=%0d want 30/5", rd, d); end
    checks++; if (mdu_a !== 32'd10 || mdu_b !== 32'd0) begin bad++; $display("FAIL div_operands: got %0d/%0d want 10/0", mdu_a, mdu_b); end
    idle(2);
  endtask

  task automatic test_ready_in_issue();
    int st, mc, dc, wc, wy; logic [4:0] rd; logic [31:0] d; logic [127:0] tr;
    run_op(mk(OP_MUL, 5'd7), 32'd3, 32'd5, 1, 2, 32'd15, 1'b0, -1, 6, st, mc, dc, wc, wy, rd, d, tr);
    checks++; if (wc !== 1 || wy !== 3) begin bad++; $display("FAIL issue_ready_timing: got count=%0d cycle=%0d want 1/3", wc, wy); end
    checks++; if (rd !== 5'd7 || d !== 32'd15) begin bad++; $display("FAIL issue_ready_value: got rd=%0d data=%0d want 7/15", rd, d); end
    idle(2);
  endtask

  task automatic test_flush_wait();
    int st, mc, dc, wc, wy; logic [4:0] rd; logic [31:0] d; logic [127:0] tr;
    run_op(mk(OP_DIV, 5'd8), 32'd20, 32'd3, 5, 5, 32'd6, 1'b0, 5, 9, st, mc, dc, wc, wy, rd, d, tr);
    checks++; if (wc !== 0) begin bad++; $display("FAIL flush_no_wb: got count=%0d want 0", wc); end
    checks++; if (st !== 6) begin bad++; $display("FAIL flush_stall_cycles: got %0d want 6", st); end
    checks++; if (tr[6] !== 1'b0) begin bad++; $display("FAIL flush_stall_release: got %0d want 0", tr[6]); end
    idle(2);
  endtask

  task automatic test_rd_zero_flush_wb();
    int st, mc, dc, wc, wy; logic [4:0] rd; logic [31:0] d; logic [127:0] tr;
    run_op(mk(OP_MUL, 5'd0), 32'd9, 32'd11, 2, 2, 32'd99, 1'b0, 3, 5, st, mc, dc, wc, wy, rd, d, tr);
    checks++; if (wc !== 1 || wy !== 3) begin bad++; $display("FAIL rd0_wb_timing: got count=%0d cycle=%0d want 1/3", wc, wy); end
    checks++; if (rd !== 5'd0 || d !== 32'd99) begin bad++; $display("FAIL rd0_wb_value: got rd=%0d data=%0d want 0/99", rd, d); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    @(posedge clock); #1; valid_x = 1'b1; ins = mk(OP_MUL, 5'd12); operand_a = 32'd4; operand_b = 32'd5;
    @(posedge clock); #1; valid_x = 1'b0;
    @(posedge clock); #1; mdu_ready = 1'b1; mdu_result = 32'd20;
    @(posedge clock); #1; mdu_ready = 1'b0; valid_x = 1'b1; ins = mk(OP_DIV, 5'd13);
    operand_a = 32'd100; operand_b = 32'd7; #1;
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd12 || wb_data !== 32'd20) begin bad++; $display("FAIL b2b_first_wb: got v=%0d rd=%0d data=%0d want 1/12/20", wb_valid, wb_rd, wb_data); end
    checks++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_wb_stall: got %0d want 0", stall); end
    @(posedge clock); #2;
    checks++; if (stall !== 1'b1 || wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_accept: got stall=%0d wb=%0d want 1/0", stall, wb_valid); end
    @(posedge clock); #1; valid_x = 1'b0; #1;
    checks++; if (ctrl_div !== 1'b1 || ctrl_mult !== 1'b0) begin bad++; $display("FAIL b2b_issue: got div=%0d mult=%0d want 1/0", ctrl_div, ctrl_mult); end
    checks++; if (mdu_a !== 32'd100 || mdu_b !== 32'd7) begin bad++; $display("FAIL b2b_operands: got %0d/%0d want 100/7", mdu_a, mdu_b); end
    @(posedge clock); #1; mdu_ready = 1'b1; mdu_result = 32'd14;
    @(posedge clock); #1; mdu_ready = 1'b0; #1;
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd13 || wb_data !== 32'd14) begin bad++; $display("FAIL b2b_second_wb: got v=%0d rd=%0d data=%0d want 1/13/14", wb_valid, wb_rd, wb_data); end
    idle(2);
  endtask

  task automatic test_ignored_instr();
    logic [31:0] v_ins[4];
    logic        v_valid[4];
    logic        v_flush[4];
    v_ins[0] = mk(OP_MUL, 5'd2, 5'b00001); v_valid[0] = 1'b1; v_flush[0] = 1'b0;
    v_ins[1] = mk(5'b01100, 5'd2);         v_valid[1] = 1'b1; v_flush[1] = 1'b0;
    v_ins[2] = mk(OP_DIV, 5'd2);           v_valid[2] = 1'b0; v_flush[2] = 1'b0;
    v_ins[3] = mk(OP_MUL, 5'd2);           v_valid[3] = 1'b1; v_flush[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      valid_x = v_valid[i]; ins = v_ins[i]; flush = v_flush[i]; operand_a = 32'hBAD0_0000 | i; #1;
      checks++; if (stall !== 1'b0) begin bad++; $display("FAIL ignore_stall[%0d]: got %0d want 0", i, stall); end
      @(posedge clock); #1; valid_x = 1'b0; flush = 1'b0; #1;
      checks++; if ({ctrl_mult, ctrl_div, wb_valid} !== 3'b000) begin bad++; $display("FAIL ignore_pulses[%0d]: got %b want 000", i, {ctrl_mult, ctrl_div, wb_valid}); end
      checks++; if (mdu_a !== 32'd100) begin bad++; $display("FAIL ignore_mdu_a[%0d]: got %0h want 64", i, mdu_a); end
    end
    idle(2);
  endtask

  task automatic test_timeout();
    int st, mc, dc, wc, wy; logic [4:0] rd; logic [31:0] d; logic [127:0] tr;
    run_op(mk(OP_MUL, 5'd6), 32'd1, 32'd1, 0, -1, 32'd0, 1'b0, 101, 103, st, mc, dc, wc, wy, rd, d, tr);
`ifdef MULTDIV_TIMEOUT_EN
    checks++; if (wc !== 1 || wy !== 42) begin bad++; $display("FAIL timeout_timing: got count=%0d cycle=%0d want 1/42", wc, wy); end
    checks++; if (rd !== 5'd30 || d !== 32'd4) begin bad++; $display("FAIL timeout_value: got rd=%0d data=%0d want 30/4", rd, d); end
    checks++; if (st !== 42) begin bad++; $display("FAIL timeout_stall_cycles: got %0d want 42", st); end
`else
    checks++; if (wc !== 0) begin bad++; $display("FAIL hold_no_wb: got count=%0d want 0", wc); end
    checks++; if (st !== 102) begin bad++; $display("FAIL hold_stall_cycles: got %0d want 102", st); end
    checks++; if (tr[102] !== 1'b0) begin bad++; $display("FAIL hold_flush_release: got %0d want 0", tr[102]); end
`endif
    idle(2);
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clock); #1; valid_x = 1'b1; ins = mk(OP_MUL, 5'd9); operand_a = 32'd11; operand_b = 32'd13;
    @(posedge clock); #1; valid_x = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1; reset_n = 1'b0; #1;
    checks++; if (mdu_a !== 32'd0 || mdu_b !== 32'd0) begin bad++; $display("FAIL rst_mid_operands: got %0h/%0h want 0/0", mdu_a, mdu_b); end
    checks++; if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin bad++; $display("FAIL rst_mid_wb: got rd=%0d data=%0h want 0/0", wb_rd, wb_data); end
    checks++; if ({stall, ctrl_mult, ctrl_div, wb_valid} !== 4'b0000) begin bad++; $display("FAIL rst_mid_ctrl: got %b want 0000", {stall, ctrl_mult, ctrl_div, wb_valid}); end
    @(posedge clock); #1;
    reset_n = 1'b1; valid_x = 1'b1; ins = mk(OP_MUL, 5'd4); operand_a = 32'd2; operand_b = 32'd3; mdu_ready = 1'b1; mdu_result = 32'd77; #1;
    checks++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_release_accept: got %0d want 1", stall); end
    @(posedge clock); #1; valid_x = 1'b0; mdu_ready = 1'b0; #1;
    checks++; if (ctrl_mult !== 1'b1 || mdu_a !== 32'd2 || wb_valid !== 1'b0) begin bad++; $display("FAIL rst_release_issue: got mult=%0d a=%0d wb=%0d want 1/2/0", ctrl_mult, mdu_a, wb_valid); end
    @(posedge clock); #1; mdu_ready = 1'b1; mdu_result = 32'd6;
    @(posedge clock); #1; mdu_ready = 1'b0; #1;
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'd6) begin bad++; $display("FAIL rst_release_wb: got v=%0d rd=%0d data=%0d want 1/4/6", wb_valid, wb_rd, wb_data); end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_div_exception();
    test_ready_in_issue();
    test_flush_wait();
    test_rd_zero_flush_wb();
    test_back_to_back();
    test_ignored_instr();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 40: watchdog limit in WAIT cycles (legal 2..63).
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 ins  input  32  X-stage instruction.
REQ-005 valid_x  input  1  X-stage instruction valid.
REQ-006 flush  input  1  pipeline flush; aborts the in-flight operation.
REQ-007 operand_a, operand_b  input  32 each  X-stage source operands.
REQ-008 mdu_a, mdu_b  output  32 each  latched operands to the multiplier/divider.
REQ-009 ctrl_mult, ctrl_div  output  1 each  one-cycle start pulses to the multiplier/divider.
REQ-010 mdu_result  input  32  multiplier/divider result.
REQ-011 mdu_exception  input  1  overflow or divide-by-zero, qualified by mdu_ready.
REQ-012 mdu_ready  input  1  result valid.
REQ-013 stall  output  1  freezes F/D/X.
REQ-014 wb_valid  output  1  writeback strobe.
REQ-015 wb_rd  output  5  writeback register.
REQ-016 wb_data  output  32  writeback data.

Function
REQ-017 Decode: R-type when ins[31:27]=00000; MUL when ins[6:2]=00110, DIV when ins[6:2]=00111; rd=ins[26:22].
REQ-018 Accept: valid_x & MUL/DIV & state IDLE & !flush; on accept, latch operands, rd and op; go to ISSUE.
REQ-019 States: IDLE, ISSUE, WAIT, WB, encoded in a 2-bit register.
REQ-020 ISSUE lasts exactly one cycle: ctrl_mult=1 for MUL or ctrl_div=1 for DIV; next state is WAIT.
REQ-021 In ISSUE, mdu_ready is ignored.
REQ-022 WAIT: on mdu_ready go to WB, capturing mdu_result and mdu_exception.
REQ-023 WB lasts one cycle: wb_valid=1, then IDLE.
REQ-024 Normal completion writes wb_rd=rd, wb_data=result.
REQ-025 On exception, wb_rd=30; wb_data=4 for MUL, 5 for DIV.
REQ-026 A MUL/DIV with rd=0 still sequences fully; wb_valid=1 with wb_rd=0 (regfile discards it).
REQ-027 stall = accept | state ISSUE | state WAIT; stall=0 in WB and IDLE, so the X instruction advances in the WB cycle.
REQ-028 Back-to-back: a new MUL/DIV is accepted no earlier than the cycle after WB; minimum latency accept->wb_valid is 3 cycles (ISSUE, WAIT with ready, WB).
REQ-029 mdu_a/mdu_b hold the latched values from accept until the next accept.
REQ-030 flush in ISSUE or WAIT returns to IDLE next cycle with no wb_valid and stall released.
REQ-031 flush and mdu_ready in the same cycle: flush wins.
REQ-032 flush in WB is ignored; the writeback completes.
REQ-033 A 6-bit wait counter clears on entry to WAIT and increments each WAIT cycle without mdu_ready.
REQ-034 Non-MUL/DIV or invalid instructions never change state or assert any output.

Reset
REQ-035 reset_n low asynchronously forces state IDLE, counter 0, and zero on all registered outputs.
REQ-036 Registered outputs: mdu_a, mdu_b, ctrl_mult, ctrl_div, wb_valid, wb_rd, wb_data.
REQ-037 stall is 0 during reset.
REQ-038 Reset mid-operation discards the operation with no writeback; the first edge after deassertion may accept.

Configuration
REQ-039 Macro MULTDIV_TIMEOUT_EN.
REQ-040 With MULTDIV_TIMEOUT_EN defined: when the counter reaches TIMEOUT in WAIT without mdu_ready, go to WB as an exception (wb_rd=30, code 4/5 per op).
REQ-041 With MULTDIV_TIMEOUT_EN undefined: no watchdog; WAIT persists until mdu_ready, flush or reset; the counter saturates at 63 with no effect.

Verification
REQ-042 MUL a=6, b=7, rd=3, ready 17 cycles after ISSUE with result 42 -> one ctrl_mult pulse; stall for 19 cycles; wb_valid, wb_rd=3, wb_data=42.
REQ-043 DIV a=10, b=0, rd=5, ready with mdu_exception=1 -> wb_rd=30, wb_data=5; no write to r5.
REQ-044 MUL with ready asserted in the same cycle as ISSUE and in the next cycle -> ready ignored in ISSUE; wb_valid exactly 3 cycles after accept.
REQ-045 DIV, flush at cycle 4 of WAIT with mdu_ready also high -> IDLE, no wb_valid, stall low next cycle.
REQ-046 With MULTDIV_TIMEOUT_EN and TIMEOUT=40, MUL never ready -> wb_valid after 40 WAIT cycles, wb_rd=30, wb_data=4; without the macro, stall is held for 100 cycles.
REQ-047 reset_n pulsed low mid-WAIT -> all outputs 0 immediately; a MUL presented after release is accepted on the next edge.
